// File: rtl/lu_pkg.sv
// Shared encodings for the AND/NAND logic-unit scheduler.
package lu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic OP_NAND = 1'b0;
  localparam logic OP_AND  = 1'b1;

endpackage

// File: rtl/lu_and_nand_vec.sv
// Combinational vector AND/NAND logic unit; out follows sel, both forms always available.
module lu_and_nand_vec
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_and,
  output logic [WIDTH-1:0] out_nand
);

  assign out_and  = a & b;
  assign out_nand = ~(a & b);

  always_comb begin
    out = out_nand;
    case (sel)
      OP_AND:  out = out_and;
      OP_NAND: out = out_nand;
      default: out = out_nand;
    endcase
  end

endmodule

// File: rtl/lu_op_scheduler.sv
// Round-robin scheduler sharing one AND/NAND unit among NREQ requesters.
// Optional build macro LU_BOTH_OUT_EN adds registered rsp_and / rsp_nand outputs.
module lu_op_scheduler
  import lu_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_op,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  input  logic                  rsp_ready
`ifdef LU_BOTH_OUT_EN
  ,
  output logic [WIDTH-1:0]      rsp_and,
  output logic [WIDTH-1:0]      rsp_nand
`endif
);

  state_t           state, state_nxt;
  logic [IDW-1:0]   lst;
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;
  logic [IDW-1:0]   id_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] lu_out, lu_and, lu_nand;

  // Round-robin pick: scan from the requester after the last one served.
  always_comb begin
    int idx;
    idx    = 0;
    grant  = '0;
    gnt_id = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(lst) + k) % NREQ;
      if (req_valid[idx] && (grant == '0)) begin
        grant[idx] = 1'b1;
        gnt_id     = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        req_ready = rst_n ? grant : '0;
        if (|grant) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  lu_and_nand_vec #(.WIDTH(WIDTH)) u_lu (
    .a        (a_q),
    .b        (b_q),
    .sel      (op_q),
    .out      (lu_out),
    .out_and  (lu_and),
    .out_nand (lu_nand)
  );

  // Operands captured at grant; result registered in EXEC, held through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lst       <= IDW'(NREQ - 1);
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            a_q  <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
            b_q  <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
            op_q <= req_op[gnt_id];
            id_q <= gnt_id;
          end
        end
        ST_EXEC: begin
          rsp_data  <= lu_out;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            lst       <= rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LU_BOTH_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_and  <= '0;
      rsp_nand <= '0;
    end else if (state == ST_EXEC) begin
      rsp_and  <= lu_and;
      rsp_nand <= lu_nand;
    end
  end
`else
  logic [WIDTH-1:0] lu_both_unused;
  assign lu_both_unused = lu_and ^ lu_nand;
`endif

endmodule
